// File: rtl/arm_pkg.sv
// Shared ARM-subset definitions: fetch FSM states, instruction field positions
// and PC arithmetic constants used by the fetch and decode logic.
package arm_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

    localparam int COND_MSB    = 31;
    localparam int COND_LSB    = 28;
    localparam int OP_MSB      = 27;
    localparam int OP_LSB      = 26;
    localparam int FUNCT_MSB   = 25;
    localparam int FUNCT_LSB   = 20;
    localparam int RD_MSB      = 15;
    localparam int RD_LSB      = 12;
    localparam int INSTR74_MSB = 7;
    localparam int INSTR74_LSB = 4;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational slicer from an instruction word to the fields the
// Controller consumes.
module instr_field_decode
    import arm_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [3:0]  instr74
);

    // Register-number and immediate bits not named here belong to later stages.
    logic unused_bits_s;

    assign cond    = instr[COND_MSB:COND_LSB];
    assign op      = instr[OP_MSB:OP_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign instr74 = instr[INSTR74_MSB:INSTR74_LSB];

    assign unused_bits_s = &{1'b0, instr[19:16], instr[11:8], instr[3:0]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory handshake and instruction register.
// Optional fetch timeout with sticky error enabled by FETCH_TIMEOUT_EN.
module fetch_unit
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [3:0]  instr74,
    output logic        fetch_err
);

    fetch_state_t state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  ir_r, ir_s;
    logic         imem_req_r;
    logic         instr_valid_r;
    logic         fetch_err_r;
    logic         unused_cfg_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int            WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    logic [WAIT_W-1:0] wait_r, wait_s;
`endif

    // Next-state, next-PC and IR capture logic.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
`ifdef FETCH_TIMEOUT_EN
        wait_s  = '0;
`endif
        case (state_r)
            FETCH: begin
                if (imem_ack) begin
                    ir_s    = imem_rdata;
                    state_s = EXEC;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // An ack in the final allowed cycle takes the branch above.
                    if (wait_r == WAIT_LAST) begin
                        state_s = ERROR;
                    end else begin
                        wait_s = wait_r + 1'b1;
                    end
`else
                    state_s = FETCH;
`endif
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_s    = pc_src ? {branch_target[31:2], 2'b00} : pc_r + PC_STEP;
                    state_s = FETCH;
                end else begin
                    state_s = EXEC;
                end
            end
            ERROR: begin
                state_s = ERROR;
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

    // State, PC, IR and registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            ir_r          <= 32'h0000_0000;
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            ir_r          <= ir_s;
            imem_req_r    <= (state_s == FETCH);
            instr_valid_r <= (state_s == EXEC);
            fetch_err_r   <= (state_s == ERROR);
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Fetch wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_r <= '0;
        end else begin
            wait_r <= wait_s;
        end
    end
`endif

    instr_field_decode u_decode (
        .instr   (ir_r),
        .cond    (cond),
        .op      (op),
        .funct   (funct),
        .rd      (rd),
        .instr74 (instr74)
    );

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = ir_r;
    assign pc          = pc_r;
    assign pc_plus8    = pc_r + PC_READ_OFFSET;
    assign fetch_err   = fetch_err_r;

    // Target alignment bits are discarded; MAX_WAIT only matters with the timeout.
    assign unused_cfg_s = &{1'b0, branch_target[1:0], (MAX_WAIT > 0)};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a memory-response scoreboard.
// Timeout scenarios run only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  instr74;
    logic        fetch_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
        .pc_plus8      (pc_plus8),
        .cond          (cond),
        .op            (op),
        .funct         (funct),
        .rd            (rd),
        .instr74       (instr74),
        .fetch_err     (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected instruction and compare the whole EXEC view.
    task automatic check_exec();
        exp_t e;
        check("instr_valid_exec", {31'd0, instr_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("pc", pc, e.addr);
            check("instr", instr, e.word);
            check("pc_plus8", pc_plus8, e.addr + 32'd8);
            check("cond", {28'd0, cond}, {28'd0, e.word[31:28]});
            check("op", {30'd0, op}, {30'd0, e.word[27:26]});
            check("funct", {26'd0, funct}, {26'd0, e.word[25:20]});
            check("rd", {28'd0, rd}, {28'd0, e.word[15:12]});
            check("instr74", {28'd0, instr74}, {28'd0, e.word[7:4]});
        end
    endtask

    // Wait (bounded) for a request, check its address, answer after delay cycles.
    task automatic fetch_issue(input logic [31:0] addr, input logic [31:0] word, input int delay);
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("imem_addr", imem_addr, addr);
        stall = (delay > 0);
        for (int i = 0; i < delay; i++) begin
            check("valid_low_wait", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
            check("addr_hold", imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb_q.push_back('{addr, word});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        stall      = 1'b0;
        check("req_low_exec", {31'd0, imem_req}, 32'd0);
        check_exec();
    endtask

    // Leave EXEC after stall_cycles of stall, optionally branching.
    task automatic exec_release(input logic branch, input logic [31:0] target, input int stall_cycles);
        logic [31:0] pc0;
        logic [31:0] ir0;
        pc0 = pc;
        ir0 = instr;
        for (int i = 0; i < stall_cycles; i++) begin
            stall         = 1'b1;
            pc_src        = ~pc_src;
            branch_target = 32'h5555_5550;
            imem_ack      = 1'b1;
            imem_rdata    = 32'hFFFF_FFFF;
            @(negedge clk);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", pc, pc0);
            check("stall_ir", instr, ir0);
            check("stall_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack      = 1'b0;
        stall         = 1'b0;
        pc_src        = branch;
        branch_target = target;
        @(negedge clk);
        pc_src = 1'b0;
        check("valid_one_cycle", {31'd0, instr_valid}, 32'd0);
        check("req_after_exec", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0000_0000;
        stall         = 1'b0;
        pc_src        = 1'b0;
        branch_target = 32'h0000_0000;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_ir", instr, 32'h0000_0000);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        reset = 1'b0;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);

        // Same-cycle ack; explicit field values for a MOV r1,#5.
        fetch_issue(32'h0000_0000, 32'hE3A0_1005, 0);
        check("t1_cond", {28'd0, cond}, 32'h0000_000E);
        check("t1_op", {30'd0, op}, 32'd0);
        check("t1_funct", {26'd0, funct}, 32'h0000_003A);
        check("t1_rd", {28'd0, rd}, 32'd1);
        check("t1_pc_plus8", pc_plus8, 32'h0000_0008);
        exec_release(1'b0, 32'h0000_0000, 0);

        // Sequential fetches with delayed acks (stall asserted during FETCH).
        fetch_issue(32'h0000_0004, 32'hE081_2003, 2);
        exec_release(1'b0, 32'h0000_0000, 0);
        fetch_issue(32'h0000_0008, 32'h1A00_00F0, 2);
        exec_release(1'b1, 32'h0000_0103, 0);

        // Branch target alignment, then a stall with pc_src toggling.
        fetch_issue(32'h0000_0100, 32'h5C9A_B7C6, 0);
        exec_release(1'b0, 32'h0000_0000, 3);
        fetch_issue(32'h0000_0104, 32'h0123_4567, 1);
        exec_release(1'b1, 32'hFFFF_FFFF, 0);

        // PC wrap at the top of the address space.
        fetch_issue(32'hFFFF_FFFC, 32'hEAFF_FFFE, 0);
        check("wrap_pc_plus8", pc_plus8, 32'h0000_0004);
        exec_release(1'b0, 32'h0000_0000, 0);
        fetch_issue(32'h0000_0000, 32'hA5A5_5A5A, 0);
        exec_release(1'b0, 32'h0000_0000, 0);

`ifdef FETCH_TIMEOUT_EN
        // Ack withheld: error after 15 FETCH cycles, sticky, cleared by reset.
        for (int i = 0; i < 14; i++) @(negedge clk);
        check("to_req_last", {31'd0, imem_req}, 32'd1);
        check("to_err_last", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        check("to_err_set", {31'd0, fetch_err}, 32'd1);
        check("to_req_low", {31'd0, imem_req}, 32'd0);
        check("to_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        repeat (5) @(negedge clk);
        imem_ack = 1'b0;
        check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
        check("to_valid_sticky", {31'd0, instr_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("to_err_rst", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("to_restart_req", {31'd0, imem_req}, 32'd1);
        check("to_restart_addr", imem_addr, 32'h0000_0000);

        // Ack in the 15th waiting cycle wins over the timeout.
        for (int i = 0; i < 14; i++) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hE12F_FF1E;
        sb_q.push_back('{32'h0000_0000, 32'hE12F_FF1E});
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_no_err", {31'd0, fetch_err}, 32'd0);
        check_exec();
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
